// File: rtl/hmem_bridge.sv
// hmem_bridge: splits hart line reads/writes into 64-bit memory beats, with a posted write buffer
module hmem_bridge #(
    parameter int LINE_W   = 256,
    parameter int WB_DEPTH = 2
) (
    input  logic              h_clk,
    input  logic              h_rst_n,
    input  logic [63:0]       h_addr,
    input  logic              h_rd,
    input  logic              h_wr,
    input  logic [LINE_W-1:0] h_data_out,
    output logic [LINE_W-1:0] h_data_in,
    output logic              h_dv,
    input  logic              h_amo_req,
    output logic              h_amo_ack,
    output logic [63:0]       m_addr,
    output logic              m_rd,
    output logic              m_wr,
    output logic [63:0]       m_wdata,
    input  logic              m_ready,
    input  logic [63:0]       m_rdata,
    input  logic              m_rvalid,
    output logic              wb_ovf
);
    localparam int BEATS = LINE_W / 64;
    localparam int OFS   = $clog2(LINE_W / 8);
    localparam int KW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int PW    = WB_DEPTH > 1 ? $clog2(WB_DEPTH) : 1;
    localparam int CW    = $clog2(WB_DEPTH + 1);
    localparam logic [63:0]   LINE_MASK = ~((64'd1 << OFS) - 64'd1);
    localparam logic [KW-1:0] LAST      = KW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, WR_BEAT, RD_BEAT, RD_WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [63:0]       wb_addr [WB_DEPTH];
    logic [LINE_W-1:0] wb_data [WB_DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count;
    logic [KW-1:0]     beat;
    logic [63:0]       rd_addr;
    logic [LINE_W-1:0] line_buf;
    logic [63:0]       line_addr, beat_ofs;
    logic              push, pop, full, empty;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(WB_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign line_addr = h_addr & LINE_MASK;
    assign beat_ofs  = 64'(beat) << 3;
    assign full      = count == CW'(WB_DEPTH);
    assign empty     = count == '0;
    assign push      = h_wr && !full;

    // Next state and memory/hart outputs; writes drain before any read starts
    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        m_rd      = 1'b0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        h_dv      = 1'b0;
        h_data_in = '0;
        case (state)
            IDLE: state_nx = !empty ? WR_BEAT : h_rd ? RD_BEAT : IDLE;
            WR_BEAT: begin
                m_wr     = 1'b1;
                m_addr   = wb_addr[head] + beat_ofs;
                m_wdata  = wb_data[head][64*beat +: 64];
                pop      = m_ready && beat == LAST;
                state_nx = pop ? IDLE : WR_BEAT;
            end
            RD_BEAT: begin
                m_rd     = 1'b1;
                m_addr   = rd_addr + beat_ofs;
                state_nx = m_ready ? RD_WAIT : RD_BEAT;
            end
            RD_WAIT: state_nx = !m_rvalid ? RD_WAIT : beat == LAST ? RESP : RD_BEAT;
            RESP: begin
                h_dv      = 1'b1;
                h_data_in = line_buf;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge h_clk) begin
        if (!h_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Beat counter, latched read address and read line assembly
    always_ff @(posedge h_clk) begin
        if (!h_rst_n) begin
            beat     <= '0;
            rd_addr  <= '0;
            line_buf <= '0;
        end else begin
            if (state == IDLE && empty && h_rd) begin
                rd_addr <= line_addr;
                beat    <= '0;
            end
            if (state == WR_BEAT && m_ready) beat <= pop ? '0 : beat + 1'b1;
            if (state == RD_WAIT && m_rvalid) begin
                line_buf[64*beat +: 64] <= m_rdata;
                beat                    <= beat == LAST ? '0 : beat + 1'b1;
            end
        end
    end

    // Write buffer storage; contents need no reset since occupancy gates use
    always_ff @(posedge h_clk) begin
        if (push) begin
            wb_addr[tail] <= line_addr;
            wb_data[tail] <= h_data_out;
        end
    end

    // Write buffer pointers, occupancy and sticky overflow
    always_ff @(posedge h_clk) begin
        if (!h_rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            wb_ovf <= 1'b0;
        end else begin
            if (push) tail <= nxt(tail);
            if (pop) head <= nxt(head);
            count <= count + CW'(push) - CW'(pop);
            if (h_wr && full) wb_ovf <= 1'b1;
        end
    end

    // AMO grant once the bridge is idle with no posted writes, held while requested
    always_ff @(posedge h_clk) begin
        if (!h_rst_n) h_amo_ack <= 1'b0;
        else          h_amo_ack <= h_amo_req && (h_amo_ack || (state == IDLE && empty));
    end
endmodule

// File: doc/hmem_bridge.md
HMEM_BRIDGE -- requirements
Module: hmem_bridge

Interface
REQ-001 Parameter LINE_W, default 256, hart memory line width in bits (equals hmem_line); SHALL be a multiple of 64.
REQ-002 Parameter WB_DEPTH, default 2, write-buffer entries.
REQ-003 Derived BEATS = LINE_W/64 and OFS = log2(LINE_W/8).
REQ-004 h_clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 h_rst_n  in  1  synchronous active-low reset.
REQ-006 h_addr  in  64  hart request byte address.
REQ-007 h_rd  in  1  read-line request level; held high until h_dv.
REQ-008 h_wr  in  1  write-line request; each high cycle is one write.
REQ-009 h_data_out  in  LINE_W  write line data from the hart.
REQ-010 h_data_in  out  LINE_W  read line data to the hart.
REQ-011 h_dv  out  1  one-cycle read-data-valid strobe.
REQ-012 h_amo_req  in  1  AMO lock request level.
REQ-013 h_amo_ack  out  1  AMO lock grant level.
REQ-014 m_addr  out  64  memory beat address, 8-byte aligned.
REQ-015 m_rd / m_wr  out  1  beat read / beat write request; never both high.
REQ-016 m_wdata  out  64  write beat data.
REQ-017 m_ready  in  1  memory accepts the request in the current cycle.
REQ-018 m_rdata  in  64  read beat data.
REQ-019 m_rvalid  in  1  m_rdata valid, one per accepted read.
REQ-020 wb_ovf  out  1  sticky write-buffer overflow flag.

Function
REQ-021 Line address SHALL be h_addr with bits [OFS-1:0] cleared; beat k address SHALL be line address + 8*k, for k = 0..BEATS-1.
REQ-022 An h_wr high cycle SHALL push {line address, h_data_out} into a FIFO write buffer in any state.
REQ-023 A push while the buffer is full SHALL be dropped and SHALL set wb_ovf, which stays set until reset.
REQ-024 FSM states: IDLE, WR_BEAT, RD_BEAT, RD_WAIT, RESP.
REQ-025 IDLE, buffer non-empty -> WR_BEAT; buffered writes always take priority over reads, so all older writes drain before a read is issued.
REQ-026 IDLE, buffer empty, h_rd high -> latch line address, beat count = 0, go to RD_BEAT.
REQ-027 WR_BEAT: drive m_wr, m_addr = beat k, m_wdata = head line bits [64k+63:64k].
  - Beat index increments on m_ready.
  - After the last beat, pop the head and return to IDLE.
REQ-028 RD_BEAT: drive m_rd with beat address. On m_ready go to RD_WAIT.
REQ-029 RD_WAIT: on m_rvalid, store m_rdata into line buffer bits [64k+63:64k].
  - k < BEATS-1: increment k, go to RD_BEAT.
  - Otherwise go to RESP.
REQ-030 RESP: assert h_dv for exactly one cycle with h_data_in = assembled line, then go to IDLE. h_dv SHALL rise the cycle after the last m_rvalid.
REQ-031 h_data_in SHALL be 0 whenever h_dv is low.
REQ-032 m_rvalid outside RD_WAIT SHALL be ignored.
REQ-033 m_rd, m_wr, m_addr and m_wdata SHALL hold stable while waiting for m_ready.
REQ-034 After RESP, h_rd SHALL NOT restart a read in the same cycle as h_dv; a new read requires h_rd to be high in IDLE.
REQ-035 h_amo_ack SHALL rise the cycle after all of the following hold: h_amo_req high, state IDLE, buffer empty.
  - It SHALL stay high while h_amo_req is high.
  - It SHALL fall the cycle after h_amo_req falls.
  - Reads and writes continue to be serviced while it is high.
REQ-036 A push and a pop in the same cycle SHALL both take effect; occupancy is unchanged.

Reset
REQ-037 While h_rst_n is low at an edge, the following SHALL be cleared: FSM to IDLE, write buffer emptied, beat count 0, line buffer 0, wb_ovf 0.
REQ-038 All outputs SHALL be 0 the cycle after reset: h_dv, h_data_in, h_amo_ack, m_rd, m_wr, m_addr, m_wdata.
REQ-039 Reset mid-transaction SHALL abort it; a pending h_dv is not delivered, and late m_rvalid is ignored.

Verification
REQ-040 Read with memory ready/valid the cycle after each request: h_addr=0x8000_0013 -> m_rd at 0x8000_0000, 0x8000_0008, 0x8000_0010, 0x8000_0018; h_dv a single cycle with beats in order; h_data_in=0 otherwise.
REQ-041 Write-before-read ordering: h_wr line 0x8000_0040 data A, then h_rd 0x8000_0040 in the next cycle -> four m_wr beats of A first, then m_rd beats; the returned line equals A.
REQ-042 Overflow: three h_wr pulses while m_ready is held low (WB_DEPTH=2) -> third write dropped, wb_ovf=1; only two lines are written after m_ready rises.
REQ-043 AMO: h_amo_req rises with one buffered write pending -> h_amo_ack stays 0 until the write drains, rises next cycle; h_amo_req falls -> h_amo_ack 0 one cycle later.
REQ-044 Reset after beat 2 of a read -> h_dv never pulses; all outputs 0; a subsequent m_rvalid is ignored; a new read completes normally.
REQ-045 Back-pressure: m_ready low for 5 cycles on each beat -> m_addr and m_rd stable throughout; the line is correct; h_dv pulses once.
